// File: rtl/bitstream_loader.sv
// Host-to-fabric configuration loader: accepts CHAIN_WORDS words and shifts each onto the chain head.
// Optional readback of the chain tail is enabled by defining BITSTREAM_LOADER_READBACK_EN.
module bitstream_loader #(
  parameter int CHAIN_WORDS = 83
) (
  input  logic                               clk,
  input  logic                               nres,
  input  logic                               cfg_start,
  input  logic                               cfg_abort,
  input  logic [31:0]                        cfg_data,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  output logic [31:0]                        prog_o,
  output logic                               prog_shft,
  input  logic [31:0]                        chain_i,
  output logic                               busy,
  output logic                               done,
  output logic                               error,
  output logic [$clog2(CHAIN_WORDS+1)-1:0]   word_cnt,
  output logic [31:0]                        rb_data,
  output logic                               rb_valid
);
  localparam int CW = $clog2(CHAIN_WORDS+1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CHAIN_WORDS);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_WORDS-1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   prog_q, prog_d;
  logic          shft_q, shft_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  always_comb begin
    state_d = state_q;
    prog_d  = prog_q;
    shft_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        // Abort wins over a word presented in the same cycle.
        if (cfg_abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else if (cfg_valid) begin
          prog_d = cfg_data;
          shft_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CNT_LAST) state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q <= S_IDLE;
      prog_q  <= '0;
      shft_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prog_q  <= prog_d;
      shft_q  <= shft_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign cfg_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign prog_o    = prog_q;
  assign prog_shft = shft_q;
  assign done      = done_q;
  assign error     = err_q;
  assign word_cnt  = cnt_q;

`ifdef BITSTREAM_LOADER_READBACK_EN
  // Tail word is sampled on the same edge the chain shifts, so it is the pre-shift tail.
  logic [31:0] rb_data_q, rb_data_d;
  logic        rb_valid_q, rb_valid_d;

  always_comb begin
    rb_data_d  = shft_q ? chain_i : rb_data_q;
    rb_valid_d = shft_q;
  end

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
`else
  logic unused_chain;
  assign unused_chain = ^chain_i;
  assign rb_data  = '0;
  assign rb_valid = 1'b0;
`endif
endmodule

// File: tb/tb_bitstream_loader.sv
// Scoreboard bench for bitstream_loader (CHAIN_WORDS=4) with a 4-word fabric chain model.
module tb_bitstream_loader;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        nres;
  logic        cfg_start, cfg_abort, cfg_valid;
  logic [31:0] cfg_data;
  logic        cfg_ready;
  logic [31:0] prog_o;
  logic        prog_shft;
  logic [31:0] chain_i;
  logic        busy, done, error;
  logic [2:0]  word_cnt;
  logic [31:0] rb_data;
  logic        rb_valid;

  bitstream_loader #(.CHAIN_WORDS(N)) dut (
    .clk(clk), .nres(nres), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .prog_o(prog_o), .prog_shft(prog_shft), .chain_i(chain_i), .busy(busy),
    .done(done), .error(error), .word_cnt(word_cnt), .rb_data(rb_data),
    .rb_valid(rb_valid)
  );

  always #5 clk = ~clk;

  // Fabric chain model: ch[0] is the head, ch[N-1] the tail.
  logic [31:0] ch [N];
  always @(posedge clk) begin
    if (prog_shft) begin
      for (int i = N-1; i > 0; i--) ch[i] <= ch[i-1];
      ch[0] <= prog_o;
    end
  end
  assign chain_i = ch[N-1];

  int checks = 0, failures = 0;
  logic [31:0] exp_shift[$];
  logic [31:0] exp_rb[$];
  int shift_cnt = 0, done_cnt = 0, run = 0, max_run = 0, rb_seen = 0;
  logic rb_arm = 1'b0;
  logic [31:0] last_prog = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expected word on every shift pulse.
  always @(negedge clk) begin
    if (!nres) begin
      last_prog = '0;
      run = 0;
    end else begin
      if (prog_shft) begin
        shift_cnt++;
        run++;
        if (run > max_run) max_run = run;
        if (exp_shift.size() == 0) chk("unexpected_shift", prog_o, 32'hFFFF_FFFF);
        else chk("prog_o", prog_o, exp_shift.pop_front());
      end else begin
        run = 0;
        chk("prog_o_hold", prog_o, last_prog);
      end
      last_prog = prog_o;
      if (done) done_cnt++;
`ifdef BITSTREAM_LOADER_READBACK_EN
      if (rb_arm && rb_valid) begin
        rb_seen++;
        if (exp_rb.size() == 0) chk("unexpected_rb", rb_data, 32'hFFFF_FFFF);
        else chk("rb_data", rb_data, exp_rb.pop_front());
      end
`else
      chk("rb_valid_off", {31'd0, rb_valid}, 32'd0);
      chk("rb_data_off", rb_data, 32'd0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // Presents a word and waits (bounded) for it to be taken; returns just after the accepting edge.
  task automatic send(input logic [31:0] d);
    int n = 0;
    cfg_data  = d;
    cfg_valid = 1'b1;
    @(negedge clk);
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) chk("send_timeout", {31'd0, cfg_ready}, 32'd1);
    else exp_shift.push_back(d);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_prog_o"}, prog_o, 0);
    chk({tag, "_prog_shft"}, {31'd0, prog_shft}, 0);
    chk({tag, "_cfg_ready"}, {31'd0, cfg_ready}, 0);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_done"}, {31'd0, done}, 0);
    chk({tag, "_error"}, {31'd0, error}, 0);
    chk({tag, "_word_cnt"}, {29'd0, word_cnt}, 0);
    chk({tag, "_rb_data"}, rb_data, 0);
    chk({tag, "_rb_valid"}, {31'd0, rb_valid}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, s0;
    logic [31:0] tbl_a [4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    logic [31:0] tbl_p [4] = '{32'h14, 32'h13, 32'h12, 32'h11};
    logic [31:0] tbl_b [4] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
    for (int i = 0; i < N; i++) ch[i] = '0;
    nres = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (3) tick();
    chk_all_zero("rst_held");
    nres = 1'b1;
    tick();
    chk_all_zero("rst_rel");

    // Full load, then extra traffic in SETTLE/IDLE
    max_run = 0; d0 = done_cnt;
    start();
    chk("ready_after_start", {31'd0, cfg_ready}, 1);
    chk("busy_load", {31'd0, busy}, 1);
    for (int i = 0; i < 4; i++) send(tbl_a[i]);
    cfg_valid = 1'b1; cfg_data = 32'hDEAD;
    chk("settle_ready", {31'd0, cfg_ready}, 0);
    chk("settle_busy", {31'd0, busy}, 1);
    chk("settle_cnt", {29'd0, word_cnt}, 4);
    chk("settle_done", {31'd0, done}, 0);
    tick();
    chk("done_pulse", {31'd0, done}, 1);
    chk("busy_fall", {31'd0, busy}, 0);
    chk("idle_ready", {31'd0, cfg_ready}, 0);
    tick();
    chk("done_once", {31'd0, done}, 0);
    tick();
    cfg_valid = 1'b0;
    chk("full_run", max_run, 4);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_cnt", {29'd0, word_cnt}, 4);

    // Stalled host with a cfg_start during LOAD
    max_run = 0; d0 = done_cnt;
    start();
    for (int i = 0; i < 4; i++) begin
      send(32'hC0 + i);
      if (i == 1) chk("stall_cnt2", {29'd0, word_cnt}, 2);
      if (i < 3) begin
        cfg_start = (i == 0);
        tick();
        cfg_start = 1'b0;
      end
    end
    repeat (3) tick();
    chk("stall_run", max_run, 1);
    chk("stall_cnt", {29'd0, word_cnt}, 4);
    chk("stall_done_cnt", done_cnt - d0, 1);

    // Abort with the third word presented
    d0 = done_cnt; s0 = shift_cnt;
    start();
    send(32'hD0);
    send(32'hD1);
    cfg_valid = 1'b1; cfg_data = 32'hD2; cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    chk("abort_error", {31'd0, error}, 1);
    chk("abort_cnt", {29'd0, word_cnt}, 2);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_ready", {31'd0, cfg_ready}, 0);
    repeat (3) tick();
    chk("abort_shifts", shift_cnt - s0, 2);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_error_sticky", {31'd0, error}, 1);
    start();
    chk("restart_error", {31'd0, error}, 0);
    chk("restart_cnt", {29'd0, word_cnt}, 0);
    // This load leaves the chain holding 0x11..0x14 with 0x14 at the tail.
    for (int i = 0; i < 4; i++) send(tbl_p[i]);
    repeat (3) tick();

    // Readback of the previous configuration
`ifdef BITSTREAM_LOADER_READBACK_EN
    exp_rb.push_back(32'h14); exp_rb.push_back(32'h13);
    exp_rb.push_back(32'h12); exp_rb.push_back(32'h11);
`endif
    rb_arm = 1'b1; rb_seen = 0;
    start();
    for (int i = 0; i < 4; i++) send(tbl_b[i]);
    repeat (4) tick();
    rb_arm = 1'b0;
`ifdef BITSTREAM_LOADER_READBACK_EN
    chk("rb_strobes", rb_seen, 4);
    chk("rb_left", exp_rb.size(), 0);
`endif

    // Async reset mid-load at word 2
    start();
    send(32'hE0);
    send(32'hE1);
    nres = 1'b0;
    #1;
    chk_all_zero("async_rst");
    exp_shift.delete();
    tick();
    #2 nres = 1'b1;
    cfg_valid = 1'b1; cfg_data = 32'hEE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_ready", {31'd0, cfg_ready}, 0);
      chk("post_rst_busy", {31'd0, busy}, 0);
      chk("post_rst_shft", {31'd0, prog_shft}, 0);
    end
    cfg_valid = 1'b0;
    tick();
    chk("shift_queue_empty", exp_shift.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
